rx_comma_aligner: RTL
=====================

RX_COMMA_ALIGNER -- requirements
Module: rx_comma_aligner

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 4, meaning symbols per frame including the leading comma (range 2..16).
REQ-002 SHALL have parameter LOCK_CNT, default 3, meaning consecutive in-slot commas required to lock (range 1..15).
REQ-003 SHALL have parameter UNLOCK_CNT, default 4, meaning consecutive comma-slot misses required to drop lock (range 1..15).
REQ-004 i_clk  input  1  system clock, 60 MHz (CLK_60M[0] domain).
REQ-005 i_res_n  input  1  reset; one clock, synchronous, active-low.
REQ-006 i_bit  input  1  recovered serial bit, 8b10b order: bit a first.
REQ-007 i_bit_vld  input  1  i_bit qualifier; at most one bit per clock, back-to-back permitted.
REQ-008 i_sfp_los  input  1  SFP loss-of-signal, high = no light.
REQ-009 o_sym  output  10  aligned symbol, o_sym[0]=a ... o_sym[9]=j.
REQ-010 o_sym_vld  output  1  one-cycle strobe qualifying o_sym.
REQ-011 o_sym_is_comma  output  1  o_sym is K28.5 (either disparity); valid with o_sym_vld.
REQ-012 o_sym_first  output  1  o_sym occupies frame slot 0; valid with o_sym_vld.
REQ-013 o_my_lock  output  1  symbol/frame alignment locked (drives LED error path and serial_rx lock status).

Function
REQ-014 SHALL shift each valid bit into a 10-bit register so the newest bit lands in sr[9] and the oldest in sr[0].
REQ-015 SHALL detect a comma when sr[0..9] equals 0011111010 (K28.5 RD-) or 1100000101 (K28.5 RD+), evaluated on the register contents including the current valid bit.
REQ-016 SHALL implement states HUNT, CHECK and LOCKED, with a 4-bit bit counter (0..9), a symbol-slot counter (0..FRAME_LEN-1), a good counter and a miss counter.
REQ-017 HUNT: SHALL test every valid bit; on a comma, SHALL set the bit counter to 0, the slot counter to 0 and the good counter to 1, then go to CHECK, or go directly to LOCKED when LOCK_CNT=1.
REQ-018 Symbol boundary SHALL be every 10th valid bit after the alignment point; the slot counter increments at each boundary and wraps from FRAME_LEN-1 to 0.
REQ-019 CHECK: at a slot-0 boundary, a comma SHALL increment the good counter and enter LOCKED when it reaches LOCK_CNT; a non-comma SHALL return to HUNT.
REQ-020 CHECK: a comma at any non-zero slot boundary SHALL return to HUNT.
REQ-021 LOCKED: at a slot-0 boundary, a comma SHALL clear the miss counter and a non-comma SHALL increment it; a comma at a non-zero slot SHALL also increment it.
REQ-022 LOCKED: when the miss counter reaches UNLOCK_CNT, SHALL go to HUNT in the same cycle; the symbol at that boundary is still emitted.
REQ-023 SHALL emit symbols only in LOCKED, including the boundary that causes the CHECK->LOCKED transition.
REQ-024 o_sym, o_sym_is_comma and o_sym_first SHALL be registered, with o_sym_vld high in exactly the cycle after the completing i_bit_vld cycle; latency is 1 clock.
REQ-025 o_sym and its flags SHALL hold their value between strobes.
REQ-026 o_my_lock SHALL be a registered decode of state==LOCKED and SHALL change 1 clock after the state transition.
REQ-027 i_sfp_los high SHALL force HUNT, clear all counters, suppress o_sym_vld and deassert o_my_lock on the next edge; it takes precedence over i_bit_vld in the same cycle.
REQ-028 Cycles with i_bit_vld low SHALL leave the shift register, counters and state unchanged.

Reset
REQ-029 On i_res_n low at a rising edge, SHALL enter HUNT with sr=0, all counters 0, o_sym=0, o_sym_vld=0, o_sym_is_comma=0, o_sym_first=0 and o_my_lock=0.
REQ-030 Reset mid-symbol or mid-lock SHALL discard the partial symbol; realignment requires LOCK_CNT new commas.

Verification
REQ-031 Defaults, frames {K28.5 RD-, D0.0 x3} sent bit-serially at 1 bit/clk -> o_my_lock rises 1 clk after the third comma's last bit; the first strobe is the comma with o_sym=0x17C and o_sym_first=1.
REQ-032 Locked link, then 4 frames with the comma replaced by D0.0 -> o_my_lock falls 1 clk after the 4th missed slot-0 boundary; 3 misses followed by 1 comma keep the lock.
REQ-033 Random 0..3-clock gaps in i_bit_vld with an RD+ comma stream -> symbols are identical to the gap-free run and each o_sym_vld lasts 1 clk.
REQ-034 In CHECK with good=2, inject a 1-bit slip -> return to HUNT, no o_sym_vld, relock after 3 commas at the new phase.
REQ-035 Locked link, assert i_sfp_los together with a symbol-completing i_bit_vld -> no strobe and o_my_lock=0 next clk; deassert -> the 3-comma relock sequence is required.
REQ-036 Assert i_res_n low for 1 clk mid-frame while locked -> all outputs 0 next clk, then relock per REQ-031.

Source files
------------

// File: rtl/rx_comma_aligner.sv
// rtl/rx_comma_aligner.sv - K28.5 symbol/frame aligner for a bit-serial 8b10b receiver
//
// Ports:
//   i_clk           system clock
//   i_res_n         synchronous active-low reset
//   i_bit           recovered serial bit, bit a first
//   i_bit_vld       qualifier for i_bit, at most one bit per clock
//   i_sfp_los       SFP loss-of-signal (high = no light), forces realignment
//   o_sym[9:0]      aligned symbol, o_sym[0]=a ... o_sym[9]=j
//   o_sym_vld       one-cycle strobe qualifying o_sym and its flags
//   o_sym_is_comma  o_sym is K28.5 of either running disparity
//   o_sym_first     o_sym occupies frame slot 0
//   o_my_lock       symbol/frame alignment locked
module rx_comma_aligner #(
    parameter int FRAME_LEN  = 4,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 4
) (
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic       i_bit,
    input  logic       i_bit_vld,
    input  logic       i_sfp_los,
    output logic [9:0] o_sym,
    output logic       o_sym_vld,
    output logic       o_sym_is_comma,
    output logic       o_sym_first,
    output logic       o_my_lock
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [9:0] K28_5_RDN  = 10'h17C;
    localparam logic [9:0] K28_5_RDP  = 10'h283;
    localparam logic [3:0] LAST_BIT   = 4'd9;
    localparam logic [3:0] LAST_SLOT  = 4'(FRAME_LEN - 1);
    localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_CNT);

    state_t     state_q, state_d;
    logic [9:0] sr_q, sr_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] slot_q, slot_d;
    logic [3:0] good_q, good_d;
    logic [3:0] miss_q, miss_d;
    logic [9:0] sym_q, sym_d;
    logic       sym_vld_q, sym_vld_d;
    logic       sym_is_comma_q, sym_is_comma_d;
    logic       sym_first_q, sym_first_d;
    logic       my_lock_q, my_lock_d;

    logic [9:0] sr_new;
    logic       comma;
    logic       boundary;
    logic [3:0] slot_next;
    logic       slot0;
    logic [3:0] good_inc;
    logic [3:0] miss_inc;
    logic       emit;
    logic       emit_first;
    logic       drop;

    always_comb begin
        // Detection looks at the register as it will be after this bit lands.
        sr_new    = {i_bit, sr_q[9:1]};
        comma     = (sr_new == K28_5_RDN) || (sr_new == K28_5_RDP);
        boundary  = (bit_cnt_q == LAST_BIT);
        slot_next = (slot_q == LAST_SLOT) ? 4'd0 : slot_q + 4'd1;
        slot0     = (slot_next == 4'd0);
        good_inc  = good_q + 4'd1;
        miss_inc  = miss_q + 4'd1;

        state_d        = state_q;
        sr_d           = sr_q;
        bit_cnt_d      = bit_cnt_q;
        slot_d         = slot_q;
        good_d         = good_q;
        miss_d         = miss_q;
        sym_d          = sym_q;
        sym_vld_d      = 1'b0;
        sym_is_comma_d = sym_is_comma_q;
        sym_first_d    = sym_first_q;
        emit           = 1'b0;
        emit_first     = 1'b0;
        drop           = 1'b0;

        if (i_sfp_los) begin
            // No light: the current bit is meaningless, so it is not shifted in.
            drop = 1'b1;
        end else if (i_bit_vld) begin
            sr_d      = sr_new;
            bit_cnt_d = boundary ? 4'd0 : bit_cnt_q + 4'd1;
            unique case (state_q)
                HUNT: begin
                    bit_cnt_d = 4'd0;
                    if (comma) begin
                        slot_d = 4'd0;
                        good_d = 4'd1;
                        miss_d = 4'd0;
                        if (LOCK_CNT == 1) begin
                            state_d    = LOCKED;
                            emit       = 1'b1;
                            emit_first = 1'b1;
                        end else begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (boundary) begin
                        slot_d = slot_next;
                        if (slot0 && comma) begin
                            good_d = good_inc;
                            if (good_inc == LOCK_TGT) begin
                                state_d    = LOCKED;
                                emit       = 1'b1;
                                emit_first = 1'b1;
                            end
                        end else if (slot0 || comma) begin
                            // Missing comma in slot 0, or a comma out of place.
                            drop = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        slot_d     = slot_next;
                        emit       = 1'b1;
                        emit_first = slot0;
                        if (slot0 && comma) begin
                            miss_d = 4'd0;
                        end else if (slot0 || comma) begin
                            miss_d = miss_inc;
                            // The symbol is still emitted on the losing boundary.
                            if (miss_inc == UNLOCK_TGT) begin
                                drop = 1'b1;
                            end
                        end
                    end
                end
                default: drop = 1'b1;
            endcase
        end

        if (drop) begin
            state_d   = HUNT;
            bit_cnt_d = 4'd0;
            slot_d    = 4'd0;
            good_d    = 4'd0;
            miss_d    = 4'd0;
        end

        if (emit) begin
            sym_vld_d      = 1'b1;
            sym_d          = sr_new;
            sym_is_comma_d = comma;
            sym_first_d    = emit_first;
        end

        // Registered from the next state so lock moves together with the strobe.
        my_lock_d = (state_d == LOCKED);
    end

    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            state_q        <= HUNT;
            sr_q           <= '0;
            bit_cnt_q      <= '0;
            slot_q         <= '0;
            good_q         <= '0;
            miss_q         <= '0;
            sym_q          <= '0;
            sym_vld_q      <= 1'b0;
            sym_is_comma_q <= 1'b0;
            sym_first_q    <= 1'b0;
            my_lock_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sr_q           <= sr_d;
            bit_cnt_q      <= bit_cnt_d;
            slot_q         <= slot_d;
            good_q         <= good_d;
            miss_q         <= miss_d;
            sym_q          <= sym_d;
            sym_vld_q      <= sym_vld_d;
            sym_is_comma_q <= sym_is_comma_d;
            sym_first_q    <= sym_first_d;
            my_lock_q      <= my_lock_d;
        end
    end

    assign o_sym          = sym_q;
    assign o_sym_vld      = sym_vld_q;
    assign o_sym_is_comma = sym_is_comma_q;
    assign o_sym_first    = sym_first_q;
    assign o_my_lock      = my_lock_q;

endmodule
